// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared constants and state encoding for the sequential divider
//   DIV_WIDTH : default operand/result width, shared with the speed unit's divider ports
//   ST_*      : state encodings (IDLE=0, RUN=1, DONE=2)
//   state_t   : FSM state type built on those encodings
package seq_divider_pkg;

    localparam int DIV_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock, fixed WIDTH-cycle latency
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset, wins over start
//   start      in   request strobe, accepted only in IDLE or DONE
//   dividend   in   WIDTH-bit numerator, sampled with accepted start
//   divisor    in   WIDTH-bit denominator, sampled with accepted start
//   Busy       out  high while iterating (exactly WIDTH cycles)
//   Ready      out  result valid level, held until next accepted start or rst
//   dividerres out  quotient (all ones on divide by zero)
//   remainder  out  remainder (dividend on divide by zero)
//   dbz        out  divide-by-zero flag for the current result
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             Busy,
    output logic             Ready,
    output logic [WIDTH-1:0] dividerres,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_r_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_r_nx;
    logic [WIDTH-1:0] w_q_nx;

    // The stored remainder only needs WIDTH bits: after each step it is below D,
    // and with D==0 the low WIDTH bits are exactly the dividend bits shifted in.
    // The full WIDTH+1-bit shifted value is kept for the compare.
    always_comb begin
        w_r_sh = {r_r, r_q[WIDTH-1]};
        w_ge   = w_r_sh >= {1'b0, r_d};
        w_diff = w_r_sh[WIDTH-1:0] - r_d;
        w_r_nx = w_ge ? w_diff : w_r_sh[WIDTH-1:0];
        w_q_nx = {r_q[WIDTH-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_q        <= '0;
            r_d        <= '0;
            r_r        <= '0;
            r_cnt      <= '0;
            Busy       <= 1'b0;
            Ready      <= 1'b0;
            dividerres <= '0;
            remainder  <= '0;
            dbz        <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_q     <= dividend;
                        r_d     <= divisor;
                        r_r     <= '0;
                        r_cnt   <= '0;
                        dbz     <= divisor == '0;
                        Busy    <= 1'b1;
                        Ready   <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_q   <= w_q_nx;
                    r_r   <= w_r_nx;
                    r_cnt <= r_cnt + 1'b1;
                    // Results are taken from the final step directly so Ready
                    // rises on the same edge as the last iteration.
                    if (r_cnt == LAST) begin
                        dividerres <= w_q_nx;
                        remainder  <= w_r_nx;
                        Busy       <= 1'b0;
                        Ready      <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
